// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of data_memory with port-1 burst lock
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_0,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic [3:0]            wren_0,
    output logic                  ack_0,
    output logic [DATA_WIDTH-1:0] rdata_0,

    input  logic                  req_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    input  logic [3:0]            wren_1,
    input  logic                  lock_1,
    output logic                  ack_1,
    output logic [DATA_WIDTH-1:0] rdata_1,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic [1:0]            owner
);

    // Burst counter holds up to MAX_BURST with headroom, and saturates rather than wraps
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW:0] MAX_BEATS = (CW + 1)'(MAX_BURST);

    // State encoding doubles as the owner output code
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic            last_owner_q, last_owner_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

    logic [CW:0]     beats;
    logic [CW-1:0]   burst_cnt_inc;
    logic            burst_stay;

    // Beat count including the current one; one bit wider so a saturated counter still compares correctly
    assign beats         = {1'b0, burst_cnt_q} + 1'b1;
    assign burst_cnt_inc = (burst_cnt_q == {CW{1'b1}}) ? burst_cnt_q : burst_cnt_q + 1'b1;
    // Port 1 keeps the bus while locked, unless port 0 is waiting and the burst has used its quota
    assign burst_stay    = lock_1 & req_1 & (~req_0 | (beats < MAX_BEATS));

    // Next-state arbitration: round-robin on ties, GNT0 is always single-beat
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                if (req_0 && req_1) begin
                    state_d = last_owner_q ? GNT0 : GNT1;
                end else if (req_0) begin
                    state_d = GNT0;
                end else if (req_1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                state_d = IDLE;
                // A dropped request is a protocol violation and does not count as a turn
                if (req_0) begin
                    last_owner_d = 1'b0;
                end
            end
            GNT1: begin
                if (!req_1) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end else if (burst_stay) begin
                    burst_cnt_d = burst_cnt_inc;
                end else begin
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                    burst_cnt_d  = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // FSM registers; last_owner resets to port 1 so port 0 wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Memory-bus mux and handshake decode from the registered owner; writes need a live request
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 4'h0;
        ack_0     = 1'b0;
        ack_1     = 1'b0;
        rdata_0   = '0;
        rdata_1   = '0;
        case (state_q)
            GNT0: begin
                mem_addr  = addr_0;
                mem_wdata = wdata_0;
                if (req_0) begin
                    mem_wren = wren_0;
                    ack_0    = 1'b1;
                    rdata_0  = mem_rdata;
                end
            end
            GNT1: begin
                mem_addr  = addr_1;
                mem_wdata = wdata_1;
                if (req_1) begin
                    mem_wren = wren_1;
                    ack_1    = 1'b1;
                    rdata_1  = mem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    assign owner = state_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported `data_memory` between the CPU load/store path (port 0) and a DMA/debug master (port 1). It sits between the CPU's ALU-result/rdata1 wiring and the `data_memory` instance. It serialises accesses with a req/ack handshake, round-robin fairness, and a bounded burst lock for port 1. Port 0 `req_0 & ~ack_0` is the CPU stall condition.

## Interface
- `ADDR_WIDTH`, 32, width of address buses.
- `DATA_WIDTH`, 32, width of data buses.
- `MAX_BURST`, 8, maximum consecutive port-1 locked beats while `req_0` is pending; must be ≥1.

One clock; reset is asynchronous and active-low. Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `req_0`, `req_1` in 1: access request; must be held with a stable payload until `ack_x`.
- `addr_0`, `addr_1` in ADDR_WIDTH: byte address.
- `wdata_0`, `wdata_1` in DATA_WIDTH: write data.
- `wren_0`, `wren_1` in 4: byte write enables; 0 means read.
- `lock_1` in 1: port 1 requests that the next beat follow immediately.
- `ack_0`, `ack_1` out 1: beat performed this cycle; write commits and rdata is valid at the closing edge.
- `rdata_0`, `rdata_1` out DATA_WIDTH: `mem_rdata` when that port is acked, else 0.
- `mem_addr` out ADDR_WIDTH, `mem_wdata` out DATA_WIDTH, `mem_wren` out 4: drive `data_memory`.
- `mem_rdata` in DATA_WIDTH: combinational read data from `data_memory`.
- `owner` out 2: 2'b00 idle, 2'b01 port 0, 2'b10 port 1.

## Operation
- FSM states are IDLE, GNT0 and GNT1. All outputs decode from registered state, `req_x`, payloads and `mem_rdata`; there is no state-less output path from `lock_1`.
- **IDLE** (memory bus: `mem_addr=0`, `mem_wdata=0`, `mem_wren=0`):
  - Only `req_0` asserted → GNT0.
  - Only `req_1` asserted → GNT1.
  - Both asserted → grant the port ≠ `last_owner`.
  - Neither asserted → stay in IDLE.
- **GNTx**:
  - Mux port x payload onto the memory bus.
  - `ack_x = req_x`.
  - `last_owner <= x` at exit.
- **GNT0 exit**: always → IDLE (one-cycle turnaround).
- **GNT1 exit**, with `beats = burst_cnt+1`:
  - Stay in GNT1 if `lock_1 & req_1 & (~req_0 | beats < MAX_BURST)`; `burst_cnt <= beats`.
  - Otherwise → IDLE and `burst_cnt <= 0`.
- A forced burst cut leaves `last_owner=1`, so a pending `req_0` wins the next IDLE arbitration.
- **Protocol violation** (`req_x` low while in GNTx):
  - `ack_x=0` and `mem_wren` forced to 0, so no write occurs.
  - → IDLE; `last_owner` is not updated.
- `burst_cnt` is `$clog2(MAX_BURST)+1` bits wide and saturates; it cannot wrap.
- **Reset values**: state IDLE, `last_owner=1` (port 0 wins the first tie), `burst_cnt=0`. All outputs 0, including `ack_x`, `rdata_x`, `mem_*` and `owner`.

## Timing
- Single beat: `req_x` rises in cycle N while IDLE → GNTx in cycle N+1 with `ack_x=1` → IDLE in N+2.
  - Unlocked throughput is one beat per 2 cycles per port.
- Locked port 1: one beat per cycle. The requester presents the next beat's payload in the cycle after each `ack_1`.
- Round-robin with both ports continuously requesting gives the sequence GNT0, IDLE, GNT1, IDLE, GNT0, …
- Maximum wait for port 0 is `MAX_BURST+1` cycles after the current port-1 beat; no starvation.
- Asynchronous reset mid-beat: `mem_wren` drops immediately on `rst` low, so the next edge performs no write. State is IDLE on release.
- `rdata_x` is valid only in the ack cycle and is combinational from `mem_rdata`.

## Test plan
- **Reset/idle**: assert `rst=0` mid-GNT1 with `wren_1=4'hF` → `mem_wren=0` instantly, the memory word is unchanged, and all outputs are 0 after release.
- **Single write then read on port 0**: write `addr 0x10`, data `0xDEADBEEF` → `ack_0` in cycle 2. Read the same address → `rdata_0=0xDEADBEEF` in the ack cycle, `owner=01`.
- **Simultaneous request after reset**: `req_0=req_1=1` → GNT0 first, then IDLE, then GNT1. The ack sequence alternates 0,1,0,1 while both are held.
- **Locked burst, no contention**: `lock_1=1`, 12 beats to `0x100..0x12C` with `req_0=0` → 12 consecutive `ack_1` cycles and all 12 words written.
- **Burst cap**: same burst, with `req_0` rising during beat 2, `MAX_BURST=8` → `ack_1` for beats 1–8, then IDLE, then GNT0 `ack_0`, then IDLE, then the remaining port-1 beats resume.
- **Violation**: drop `req_1` during GNT1 with `wren_1=4'h3` → no `ack_1`, no write, return to IDLE, `last_owner` unchanged.
